// File: rtl/ws2812b_pkg.sv
// Shared types and constants for the ws2812b frame scheduler: GRB pixel format,
// stock colours and the scheduler FSM state encoding.
package ws2812b_pkg;

  localparam int unsigned PIXEL_W = 24;

  typedef logic [PIXEL_W-1:0] grb_t;

  // Pixel words are {G,R,B}.
  localparam grb_t COLOR_OFF   = 24'h000000;
  localparam grb_t COLOR_RED   = 24'h00FF00;
  localparam grb_t COLOR_GREEN = 24'hFF0000;
  localparam grb_t COLOR_BLUE  = 24'h0000FF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SEND  = 2'd2,
    ST_LATCH = 2'd3
  } sched_state_e;

endpackage

// File: rtl/ws2812b_tick_gen.sv
// Terminal-count pulse generator: counts 0..terminal, pulses tick on the last
// count and wraps to 0; clear restarts the count from 0.
module ws2812b_tick_gen #(
  parameter int unsigned W = 8
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         clear,
  input  logic [W-1:0] terminal,
  output logic         tick
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // NOTE: next-state is computed with blocking '=' in always_comb, with every
  // output given a default first so no latch can be inferred.
  always_comb begin
    tick  = (cnt_q == terminal);
    cnt_d = cnt_q + W'(1);
    if (clear || tick) begin
      cnt_d = '0;
    end
  end

  // NOTE: flops are written only with non-blocking '<=' so every register
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ws2812b_frame_scheduler.sv
// Frame scheduler for a ws2812b strip: double-buffered pixel store plus a
// periodic LOAD/SEND/LATCH sequence that gates the serializer enable.
module ws2812b_frame_scheduler
  import ws2812b_pkg::*;
#(
  parameter int unsigned NUM_LEDS     = 8,
  parameter int unsigned ADDR_W       = 3,
  parameter int unsigned FRAME_TICKS  = 25000000,
  parameter int unsigned LATCH_TICKS  = 14000,
  parameter int unsigned SEND_TIMEOUT = 1000000
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        wr_en,
  input  logic [ADDR_W-1:0]           wr_addr,
  input  logic [PIXEL_W-1:0]          wr_data,
  input  logic                        commit,
  output logic                        commit_pending,
  output logic [PIXEL_W*NUM_LEDS-1:0] pixels,
  output logic                        drv_enable,
  input  logic                        drv_done,
  output logic                        busy,
  output logic [15:0]                 frame_count,
  output logic                        timeout_err
);

  localparam int unsigned LATCH_EFF = (LATCH_TICKS == 0) ? 1 : LATCH_TICKS;
  localparam int unsigned PHASE_MAX = (SEND_TIMEOUT > LATCH_EFF) ? SEND_TIMEOUT : LATCH_EFF;
  localparam int unsigned PHASE_W   = $clog2(PHASE_MAX + 1);
  localparam int unsigned FRAME_W   = $clog2(FRAME_TICKS);

  localparam logic [FRAME_W-1:0] FRAME_TERM = FRAME_W'(FRAME_TICKS - 1);
  // SEND lets the enable stay high for SEND_TIMEOUT clocks before aborting.
  localparam logic [PHASE_W-1:0] SEND_TERM  = PHASE_W'(SEND_TIMEOUT);
  localparam logic [PHASE_W-1:0] LATCH_TERM = PHASE_W'(LATCH_EFF - 1);

  sched_state_e state_q, state_d;
  grb_t         shadow_q [NUM_LEDS];
  grb_t         shadow_d [NUM_LEDS];
  grb_t         active_q [NUM_LEDS];
  grb_t         active_d [NUM_LEDS];
  logic         commit_pending_q, commit_pending_d;
  logic         drv_enable_q, drv_enable_d;
  logic [15:0]  frame_count_q, frame_count_d;
  logic         timeout_err_q, timeout_err_d;

  logic               frame_tick;
  logic               phase_tick;
  logic               phase_clear;
  logic [PHASE_W-1:0] phase_term;

  ws2812b_tick_gen #(.W(FRAME_W)) u_frame_tick (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear    (1'b0),
    .terminal (FRAME_TERM),
    .tick     (frame_tick)
  );

  // Shared by SEND (timeout) and LATCH (gap); restarted on every state change.
  ws2812b_tick_gen #(.W(PHASE_W)) u_phase_tick (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear    (phase_clear),
    .terminal (phase_term),
    .tick     (phase_tick)
  );

  assign phase_term  = (state_q == ST_SEND) ? SEND_TERM : LATCH_TERM;
  assign phase_clear = ((state_q != ST_SEND) && (state_q != ST_LATCH)) || (state_d != state_q);

  always_comb begin
    shadow_d = shadow_q;
    if (wr_en && (32'(wr_addr) < NUM_LEDS)) begin
      shadow_d[wr_addr] = wr_data;
    end
  end

  always_comb begin
    state_d          = state_q;
    active_d         = active_q;
    commit_pending_d = commit_pending_q;
    drv_enable_d     = 1'b0;
    frame_count_d    = frame_count_q;
    timeout_err_d    = timeout_err_q;

    case (state_q)
      ST_IDLE: begin
        if (frame_tick) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        // Copy sees the pre-edge shadow, so a same-cycle write waits a frame.
        if (commit_pending_q) begin
          active_d         = shadow_q;
          commit_pending_d = 1'b0;
        end
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (drv_done) begin
          state_d       = ST_LATCH;
          frame_count_d = frame_count_q + 16'd1;
        end else if (phase_tick) begin
          state_d       = ST_LATCH;
          timeout_err_d = 1'b1;
        end else begin
          drv_enable_d = 1'b1;
        end
      end
      ST_LATCH: begin
        if (phase_tick) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A commit landing on the LOAD cycle re-arms after the copy clears it.
    if (commit) commit_pending_d = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= ST_IDLE;
      // NOTE: the banks are small flop arrays rather than RAM, so they take the
      // async reset and the strip is guaranteed dark after reset_n.
      shadow_q         <= '{default: COLOR_OFF};
      active_q         <= '{default: COLOR_OFF};
      commit_pending_q <= 1'b0;
      drv_enable_q     <= 1'b0;
      frame_count_q    <= '0;
      timeout_err_q    <= 1'b0;
    end else begin
      state_q          <= state_d;
      shadow_q         <= shadow_d;
      active_q         <= active_d;
      commit_pending_q <= commit_pending_d;
      drv_enable_q     <= drv_enable_d;
      frame_count_q    <= frame_count_d;
      timeout_err_q    <= timeout_err_d;
    end
  end

  always_comb begin
    pixels = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      pixels[PIXEL_W*(NUM_LEDS-i)-1 -: PIXEL_W] = active_q[i];
    end
  end

  assign commit_pending = commit_pending_q;
  assign drv_enable     = drv_enable_q;
  assign busy           = (state_q != ST_IDLE);
  assign frame_count    = frame_count_q;
  assign timeout_err    = timeout_err_q;

endmodule

// File: tb/tb_ws2812b_frame_scheduler.sv
// Directed bench for ws2812b_frame_scheduler with a serializer model that
// pulses drv_done 100 clocks after drv_enable rises.
module tb_ws2812b_frame_scheduler;
  import ws2812b_pkg::*;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         wr_en = 1'b0;
  logic [2:0]   wr_addr = '0;
  logic [23:0]  wr_data = '0;
  logic         commit = 1'b0;
  logic         stray_done = 1'b0;
  logic         model_done = 1'b0;
  logic         model_on = 1'b1;
  logic         drv_done;

  logic         commit_pending, drv_enable, busy, timeout_err;
  logic [191:0] pixels;
  logic [15:0]  frame_count;
  logic         commit_pending6, drv_enable6, busy6, timeout_err6;
  logic [143:0] pixels6;
  logic [15:0]  frame_count6;

  int errors = 0;
  int checks = 0;
  int exp_fc = 0;
  int en_cnt = 0;
  int en_cycles;

  logic [23:0] sh8 [8] = '{default: '0};
  logic [23:0] act8 [8] = '{default: '0};
  logic [23:0] sh6 [6] = '{default: '0};
  logic [23:0] act6 [6] = '{default: '0};

  assign drv_done = model_done | stray_done;

  ws2812b_frame_scheduler #(
    .NUM_LEDS(8), .ADDR_W(3), .FRAME_TICKS(500), .LATCH_TICKS(20), .SEND_TIMEOUT(300)
  ) dut (
    .clock(clock), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .commit(commit), .commit_pending(commit_pending), .pixels(pixels), .drv_enable(drv_enable),
    .drv_done(drv_done), .busy(busy), .frame_count(frame_count), .timeout_err(timeout_err)
  );

  ws2812b_frame_scheduler #(
    .NUM_LEDS(6), .ADDR_W(3), .FRAME_TICKS(500), .LATCH_TICKS(20), .SEND_TIMEOUT(300)
  ) dut6 (
    .clock(clock), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .commit(commit), .commit_pending(commit_pending6), .pixels(pixels6), .drv_enable(drv_enable6),
    .drv_done(drv_done), .busy(busy6), .frame_count(frame_count6), .timeout_err(timeout_err6)
  );

  always #5 clock = ~clock;

  // Serializer model: done pulse sampled on the 101st enabled clock.
  always @(negedge clock) begin
    if (!reset_n || !drv_enable) en_cnt = 0;
    else en_cnt = en_cnt + 1;
    model_done = model_on && (en_cnt == 101);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [191:0] pack8();
    logic [191:0] v;
    for (int i = 0; i < 8; i++) v[191-24*i -: 24] = act8[i];
    return v;
  endfunction

  function automatic logic [143:0] pack6();
    logic [143:0] v;
    for (int i = 0; i < 6; i++) v[143-24*i -: 24] = act6[i];
    return v;
  endfunction

  task automatic write_px(input logic [2:0] a, input logic [23:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clock);
    wr_en = 1'b0;
    sh8[a] = d;
    if (int'(a) < 6) sh6[a] = d;
  endtask

  task automatic do_commit();
    commit = 1'b1;
    @(negedge clock);
    commit = 1'b0;
  endtask

  task automatic wait_busy(input logic want, input string what);
    int n = 0;
    while (busy !== want && n < 1000) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (busy !== want) begin
      errors++;
      $display("FAIL %s: busy=%b after %0d cycles, required %b", what, busy, n, want);
    end
  endtask

  task automatic run_frame(output int en_hi);
    int n = 0;
    wait_busy(1'b0, "frame_idle");
    wait_busy(1'b1, "frame_start");
    en_hi = 0;
    while (busy === 1'b1 && n < 1000) begin
      @(negedge clock);
      n++;
      if (drv_enable === 1'b1) en_hi++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL frame_end: still busy after %0d cycles", n);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if ({drv_enable, busy, commit_pending, timeout_err} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got %b, required 0000", {drv_enable, busy, commit_pending, timeout_err});
    end
    checks++;
    if (pixels !== '0 || frame_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_data: pixels=%h frame_count=%0d, required 0/0", pixels, frame_count);
    end
    reset_n = 1'b1;
    repeat (501) @(posedge clock);
    @(negedge clock);
    checks++;
    if (drv_enable !== 1'b0) begin
      errors++;
      $display("FAIL enable_cycle_501: drv_enable=%b, required 0", drv_enable);
    end
    @(negedge clock);
    checks++;
    if (drv_enable !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL enable_cycle_502: drv_enable=%b busy=%b, required 1/1", drv_enable, busy);
    end
  endtask

  task automatic test_commit();
    wait_busy(1'b0, "commit_idle");
    exp_fc++;
    write_px(3'd0, COLOR_RED);
    write_px(3'd7, COLOR_GREEN);
    do_commit();
    checks++;
    if (commit_pending !== 1'b1) begin
      errors++;
      $display("FAIL commit_set: commit_pending=%b, required 1", commit_pending);
    end
    wait_busy(1'b1, "commit_load");
    checks++;
    if (commit_pending !== 1'b1 || pixels !== pack8()) begin
      errors++;
      $display("FAIL commit_in_load: pending=%b pixels=%h, required 1/%h", commit_pending, pixels, pack8());
    end
    @(negedge clock);
    act8 = sh8;
    act6 = sh6;
    checks++;
    if (commit_pending !== 1'b0) begin
      errors++;
      $display("FAIL commit_cleared: commit_pending=%b, required 0", commit_pending);
    end
    checks++;
    if (pixels[191:168] !== 24'h00FF00 || pixels[23:0] !== 24'hFF0000) begin
      errors++;
      $display("FAIL commit_pixels: p0=%h p7=%h, required 00ff00/ff0000", pixels[191:168], pixels[23:0]);
    end
    wait_busy(1'b0, "commit_done");
    exp_fc++;
    checks++;
    if (frame_count !== 16'(exp_fc)) begin
      errors++;
      $display("FAIL commit_frame_count: got %0d, required %0d", frame_count, exp_fc);
    end
  endtask

  task automatic test_no_commit();
    write_px(3'd3, COLOR_BLUE);
    write_px(3'd4, 24'h0A0B0C);
    for (int f = 0; f < 3; f++) begin
      run_frame(en_cycles);
      exp_fc++;
      checks++;
      if (en_cycles != 101) begin
        errors++;
        $display("FAIL nocommit_enable_len[%0d]: got %0d cycles, required 101", f, en_cycles);
      end
      checks++;
      if (pixels !== pack8() || frame_count !== 16'(exp_fc)) begin
        errors++;
        $display("FAIL nocommit_frame[%0d]: pixels=%h fc=%0d, required %h/%0d", f, pixels, frame_count, pack8(), exp_fc);
      end
    end
  endtask

  task automatic test_timeout();
    model_on = 1'b0;
    run_frame(en_cycles);
    checks++;
    if (en_cycles != 300) begin
      errors++;
      $display("FAIL timeout_enable_len: got %0d cycles, required 300", en_cycles);
    end
    checks++;
    if (timeout_err !== 1'b1 || frame_count !== 16'(exp_fc)) begin
      errors++;
      $display("FAIL timeout_flags: err=%b fc=%0d, required 1/%0d", timeout_err, frame_count, exp_fc);
    end
    model_on = 1'b1;
    run_frame(en_cycles);
    exp_fc++;
    checks++;
    if (en_cycles != 101 || timeout_err !== 1'b1 || frame_count !== 16'(exp_fc)) begin
      errors++;
      $display("FAIL timeout_recover: len=%0d err=%b fc=%0d, required 101/1/%0d", en_cycles, timeout_err, frame_count, exp_fc);
    end
  endtask

  task automatic test_commit_in_load();
    wait_busy(1'b0, "cil_idle");
    wait_busy(1'b1, "cil_load");
    commit = 1'b1; wr_en = 1'b1; wr_addr = 3'd1; wr_data = 24'h123456;
    @(negedge clock);
    commit = 1'b0; wr_en = 1'b0;
    sh8[1] = 24'h123456;
    sh6[1] = 24'h123456;
    checks++;
    if (commit_pending !== 1'b1 || pixels !== pack8()) begin
      errors++;
      $display("FAIL cil_after_load: pending=%b pixels=%h, required 1/%h", commit_pending, pixels, pack8());
    end
    wait_busy(1'b0, "cil_done1");
    exp_fc++;
    wait_busy(1'b1, "cil_load2");
    @(negedge clock);
    act8 = sh8;
    act6 = sh6;
    checks++;
    if (pixels[167:144] !== 24'h123456 || pixels !== pack8() || commit_pending !== 1'b0) begin
      errors++;
      $display("FAIL cil_next_frame: p1=%h pending=%b, required 123456/0", pixels[167:144], commit_pending);
    end
    wait_busy(1'b0, "cil_done2");
    exp_fc++;
    checks++;
    if (frame_count !== 16'(exp_fc)) begin
      errors++;
      $display("FAIL cil_frame_count: got %0d, required %0d", frame_count, exp_fc);
    end
  endtask

  task automatic test_ignored();
    wait_busy(1'b0, "ign_idle");
    write_px(3'd7, 24'hABCDEF);
    write_px(3'd5, 24'h0F0F0F);
    do_commit();
    stray_done = 1'b1;
    @(negedge clock);
    stray_done = 1'b0;
    @(negedge clock);
    checks++;
    if (busy !== 1'b0 || drv_enable !== 1'b0 || frame_count !== 16'(exp_fc)) begin
      errors++;
      $display("FAIL stray_done: busy=%b en=%b fc=%0d, required 0/0/%0d", busy, drv_enable, frame_count, exp_fc);
    end
    run_frame(en_cycles);
    exp_fc++;
    act8 = sh8;
    act6 = sh6;
    checks++;
    if (pixels6 !== pack6() || pixels6[23:0] !== 24'h0F0F0F) begin
      errors++;
      $display("FAIL addr_ignored6: pixels6=%h, required %h", pixels6, pack6());
    end
    checks++;
    if (pixels[23:0] !== 24'hABCDEF || frame_count !== 16'(exp_fc)) begin
      errors++;
      $display("FAIL addr7_accepted8: p7=%h fc=%0d, required abcdef/%0d", pixels[23:0], frame_count, exp_fc);
    end
  endtask

  task automatic test_reset_mid_send();
    wait_busy(1'b0, "rst_idle");
    wait_busy(1'b1, "rst_load");
    repeat (5) @(negedge clock);
    checks++;
    if (drv_enable !== 1'b1 || timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL rst_precondition: en=%b err=%b, required 1/1", drv_enable, timeout_err);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({drv_enable, busy, commit_pending, timeout_err} !== 4'b0000 || pixels !== '0 || frame_count !== 16'd0) begin
      errors++;
      $display("FAIL async_reset: en=%b busy=%b pend=%b err=%b fc=%0d pixels=%h, required all 0",
               drv_enable, busy, commit_pending, timeout_err, frame_count, pixels);
    end
    checks++;
    if ({drv_enable6, busy6, commit_pending6, timeout_err6} !== 4'b0000 || frame_count6 !== 16'd0 || pixels6 !== '0) begin
      errors++;
      $display("FAIL async_reset6: en=%b busy=%b fc=%0d, required 0", drv_enable6, busy6, frame_count6);
    end
    @(negedge clock);
    reset_n = 1'b1;
    repeat (501) @(posedge clock);
    @(negedge clock);
    checks++;
    if (drv_enable !== 1'b0) begin
      errors++;
      $display("FAIL rst_enable_501: drv_enable=%b, required 0", drv_enable);
    end
    @(negedge clock);
    checks++;
    if (drv_enable !== 1'b1) begin
      errors++;
      $display("FAIL rst_enable_502: drv_enable=%b, required 1", drv_enable);
    end
  endtask

  initial begin
    test_reset();
    test_commit();
    test_no_commit();
    test_timeout();
    test_commit_in_load();
    test_ignored();
    test_reset_mid_send();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
